// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin burst scheduler feeding the Select input of a registered 4:1 mux.
// Revision: 1.0
`default_nettype none

module mux4_rr_sched #(
  parameter int MAX_BURST = 8,
  parameter int bw_cnt    = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [3:0] Req,
  output logic [1:0] Select,
  output logic [3:0] Grant,
  output logic       Busy,
  output logic       OutValid,
  output logic       BurstLast
);

  localparam logic [bw_cnt-1:0] C_MAX = bw_cnt'(MAX_BURST);
  localparam logic [bw_cnt-1:0] C_ONE = bw_cnt'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        grant_q, grant_d;
  logic [bw_cnt-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  logic              w_found_ptr, w_found_next;
  logic [1:0]        w_win_ptr, w_win_next;
  logic [1:0]        w_next_start;
  logic              w_continue;

  // Returns {found, index} of the first requester at or after start, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_next_start                = sel_q + 2'd1;
  assign {w_found_ptr, w_win_ptr}    = rr_pick(Req, ptr_q);
  assign {w_found_next, w_win_next}  = rr_pick(Req, w_next_start);
  assign w_continue                  = Req[sel_q] & Enable & (cnt_q < C_MAX);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    last_d  = 1'b0;
    valid_d = |(grant_q & Req);

    case (state_q)
      S_IDLE: begin
        if (Enable && w_found_ptr) begin
          state_d = S_GRANT;
          sel_d   = w_win_ptr;
          grant_d = 4'b0001 << w_win_ptr;
          cnt_d   = C_ONE;
          last_d  = (C_ONE == C_MAX);
        end
      end
      S_GRANT: begin
        if (w_continue) begin
          cnt_d  = cnt_q + C_ONE;
          last_d = ((cnt_q + C_ONE) == C_MAX);
        end else begin
          ptr_d = w_next_start;
          // Searching from c+1 puts c last, so it only wins as the sole requester.
          if (Enable && w_found_next) begin
            sel_d   = w_win_next;
            grant_d = 4'b0001 << w_win_next;
            cnt_d   = C_ONE;
            last_d  = (C_ONE == C_MAX);
          end else begin
            state_d = S_IDLE;
            grant_d = 4'b0000;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign Select    = sel_q;
  assign Grant     = grant_q;
  assign Busy      = (state_q == S_GRANT);
  assign OutValid  = valid_q;
  assign BurstLast = last_q;

endmodule

`default_nettype wire
